// File: rtl/proc_pkg.sv
// Shared loader definitions: default frame header, default
// imem address width and the loader state encoding.
package proc_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam logic [7:0]  HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM
  } ld_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts bytes into a little-endian 32-bit word.
// Ports: clk, rst_n, i_clr, i_valid, i_byte -> o_word, o_done.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [23:0] r_word;
  logic [1:0]  r_idx;

  // Strobe and full word are combinational so the
  // parent can register them on the 4th-byte edge.
  assign o_done = i_valid & (r_idx == 2'd3);
  assign o_word = {i_byte, r_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_valid) begin
      unique case (r_idx)
        2'd0:    r_word[7:0]   <= i_byte;
        2'd1:    r_word[15:8]  <= i_byte;
        2'd2:    r_word[23:16] <= i_byte;
        default: r_word        <= '0;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> sequential imem writes.
// Ports: clk, reset(n), in_*, imem_*, cpu_hold, load_done/err.
import proc_pkg::*;

module imem_loader #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [7:0]  HEADER = HEADER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  ld_state_t r_state;
  ld_state_t w_next;

  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_widx;
  logic [7:0]        r_xor;

  logic        w_acc;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last;
  logic        w_pk_clr;
  logic        w_pk_vld;
  logic        w_pk_done;
  logic [31:0] w_pk_word;

  assign in_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

  assign w_acc     = in_valid & r_ready;
  assign w_len     = {in_data, r_len_lo};
  assign w_len_bad = (w_len == 16'd0) ||
                     (32'(w_len) > (32'd1 << ADDR_W));
  // Index is one bit wider than the address so a
  // full-size frame ends without wrapping.
  assign w_last    = (32'(r_widx) + 32'd1) == 32'(r_len);
  assign w_pk_clr  = w_acc & (r_state == S_LEN_HI);
  assign w_pk_vld  = w_acc & (r_state == S_DATA);

  word_packer u_pk (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_pk_clr),
    .i_valid (w_pk_vld),
    .i_byte  (in_data),
    .o_word  (w_pk_word),
    .o_done  (w_pk_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_acc && in_data == HEADER) w_next = S_LEN_LO;
      S_LEN_LO:
        if (w_acc) w_next = S_LEN_HI;
      S_LEN_HI:
        if (w_acc) w_next = w_len_bad ? S_IDLE : S_DATA;
      S_DATA:
        if (w_pk_done && w_last) w_next = S_CSUM;
      S_CSUM:
        if (w_acc) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_len_lo <= '0;
      r_len    <= '0;
      r_widx   <= '0;
      r_xor    <= '0;
    end else begin
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          S_IDLE:
            if (in_data == HEADER) begin
              r_hold <= 1'b1;
              r_err  <= 1'b0;
            end
          S_LEN_LO:
            r_len_lo <= in_data;
          S_LEN_HI: begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_widx <= '0;
              r_xor  <= '0;
            end
          end
          S_DATA: begin
            r_xor <= r_xor ^ in_data;
            if (w_pk_done) begin
              r_we    <= 1'b1;
              r_addr  <= r_widx[ADDR_W-1:0];
              r_wdata <= w_pk_word;
              r_widx  <= r_widx + 1'b1;
            end
          end
          S_CSUM:
            if (in_data == r_xor) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

endmodule
